uart_tx_fifo_param: RTL and testbench
=====================================

Name: uart_tx_fifo_param

Overview:
Parametrised successor to the fixed 8N1 UART transmit path in customUartTop. Frame format is configurable: data width, parity mode and stop-bit count. A synchronous FIFO buffers writes so software or upstream logic can queue bytes while a frame is on the line. Queued frames go out back-to-back with no idle gap. The block sits between the system-clock fabric and the tx pin; the rx path is untouched.

Parameters:
SYSTEM_CLOCK, 100000000, system_clk frequency in Hz
UART_BAUDRATE, 115200, line rate in baud; CLKS_PER_BIT = SYSTEM_CLOCK/UART_BAUDRATE, integer truncation, must be >= 4
DATA_BITS, 8, data bits per frame, legal range 5..9
PARITY_MODE, 0, 0 = none, 1 = odd, 2 = even
STOP_BITS, 1, stop-bit count, legal values 1 or 2
FIFO_DEPTH, 16, FIFO entries, power of 2, >= 2

Ports:
system_clk  in  1  sole clock
reset  in  1  synchronous reset, active-high
din  in  DATA_BITS  write data
wr_en  in  1  write strobe; one entry per cycle high
full  out  1  FIFO full
fifo_count  out  $clog2(FIFO_DEPTH)+1  entries currently queued, excluding the frame in flight
overflow  out  1  one-cycle pulse when a write is dropped
tx  out  1  serial line, registered, idle high
tx_busy  out  1  high while a frame is on the line

Behaviour:
- Reset (sync, active-high, wins over all other inputs):
  - tx=1, tx_busy=0, full=0, fifo_count=0, overflow=0.
  - FIFO pointers cleared, baud counter cleared, FSM to IDLE.
  - Reset mid-frame aborts the frame immediately; tx returns high on the next edge.
- Write rule:
  - wr_en && !full: push din.
  - wr_en && full: write dropped, overflow=1 for one cycle, FIFO contents unchanged.
  - full is evaluated before any same-cycle pop, so a write while full is dropped even if a pop happens in the same cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx=1. If FIFO not empty: pop into shift register, go to START.
  - START: tx=0 for CLKS_PER_BIT cycles.
  - DATA: DATA_BITS bits, LSB first, CLKS_PER_BIT cycles each.
  - PARITY: entered only if PARITY_MODE!=0. Bit is XOR of data (even) or its inverse (odd).
  - STOP: tx=1 for STOP_BITS*CLKS_PER_BIT cycles.
  - End of STOP: if FIFO not empty, pop and go to START on the same edge (back-to-back, tx_busy stays high); otherwise go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1 and restarts on each state entry. No fractional-baud accumulation.
- Latency: wr_en sampled at edge E0 with FIFO empty and FSM in IDLE -> tx and tx_busy change at edge E0+2.
- tx_busy falls on the edge that completes the last stop bit when nothing is queued.
- Frame length in cycles: (1 + DATA_BITS + (PARITY_MODE!=0) + STOP_BITS) * CLKS_PER_BIT.
- Simultaneous push and pop in one cycle: fifo_count unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- full = (fifo_count == FIFO_DEPTH).
- Unused upper bits of din (when DATA_BITS < width) are ignored.

Optional Feature:
UART_TX_BREAK_EN:
- Defined: adds input port tx_break (1 bit).
  - While tx_break=1 and FSM is IDLE, tx is held 0 and tx_busy=1.
  - A frame already in progress finishes before break takes effect.
  - FIFO pops are suspended while break is active.
  - On release, tx returns to 1 for one full bit time before the next start bit.
- Undefined: the port is absent, and tx is never low outside START/DATA/PARITY bits.

Decomposition:
- uart_pkg holds:
  - PARITY_NONE/ODD/EVEN constants
  - FSM state encoding
  - clog2 helper function
  - CLKS_PER_BIT calculation function
- Sub-module uart_sync_fifo (parameters WIDTH, DEPTH) provides push/pop/full/empty/count.
- The top holds the FSM, baud counter and shift register.

Test Plan:
- SYSTEM_CLOCK=1600, UART_BAUDRATE=100 (16 clk/bit), 8N1, write 0xA5 -> tx low at E0+2. Bits sampled mid-bit are 0,1,0,1,0,0,1,0,1,1. tx_busy high for exactly 160 cycles.
- Same clocking, 8E1 then 8O1 with 0xA5 -> parity bit 0 (even) and 1 (odd); frame 176 cycles.
- Write 0x5A, 0xAA, 0x3C on three consecutive cycles -> three frames back-to-back, tx_busy continuously high for 480 cycles, fifo_count peaks at 2.
- FIFO_DEPTH=4, issue 6 writes while busy -> full asserts after 4 accepted entries. Remaining writes each pulse overflow once. Only 5 frames are sent: 1 in flight plus 4 queued.
- DATA_BITS=7, STOP_BITS=2, write 0x55 -> 7 data bits then 32 cycles high; total frame 160 cycles.
- Reset asserted at cycle 50 of a frame -> tx=1 and tx_busy=0 on the next edge, fifo_count=0, no further frames sent.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared constants, FSM state encoding and small elaboration-time
// helpers for the parametrised UART transmit path.
//   PARITY_NONE/ODD/EVEN : values for the PARITY_MODE parameter
//   tx_state_e           : transmit FSM state encoding
//   clog2()              : ceiling log2, used for counter/pointer widths
//   clks_per_bit()       : system clocks per line bit (truncating divide)
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_param_if.sv
// uart_tx_fifo_param_if: write-side handshake and line outputs of the UART
// transmitter.
//   din, wr_en          : write data / strobe (master -> slave)
//   full, fifo_count    : FIFO status (slave -> master)
//   overflow            : dropped-write pulse (slave -> master)
//   tx, tx_busy         : serial line and frame-active flag (slave -> master)
interface uart_tx_fifo_param_if #(
  parameter int DATA_BITS = 8,
  parameter int CNT_W     = 5
);
  logic [DATA_BITS-1:0] din;
  logic                 wr_en;
  logic                 full;
  logic [CNT_W-1:0]     fifo_count;
  logic                 overflow;
  logic                 tx;
  logic                 tx_busy;

  modport master (output din, wr_en,
                  input  full, fifo_count, overflow, tx, tx_busy);
  modport slave  (input  din, wr_en,
                  output full, fifo_count, overflow, tx, tx_busy);
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO, power-of-2 depth, show-ahead read.
//   clk, rst      : clock, synchronous active-high reset (clears pointers/count)
//   push, wdata   : write (caller guarantees !full)
//   pop, rdata    : read; rdata is the head entry, valid while !empty
//   full, empty   : status
//   count         : entries held, 0..DEPTH
module uart_sync_fifo import uart_pkg::*; #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [clog2(DEPTH):0]  count
);
  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;

  // storage needs no reset: pointers define validity
  always_ff @(posedge clk)
    if (push) mem[wp] <= wdata;

  // pointers wrap naturally because DEPTH is a power of 2
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop)  rp <= rp + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign rdata = mem[rp];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
endmodule

// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: FIFO-buffered UART transmitter with configurable frame
// (DATA_BITS 5..9, PARITY_MODE none/odd/even, STOP_BITS 1..2).
//   system_clk, reset : clock, synchronous active-high reset
//   tx_break          : (only with UART_TX_BREAK_EN) hold line low when idle
//   bus (slave)       : din/wr_en in; full, fifo_count, overflow, tx, tx_busy out
// Optional feature macro: UART_TX_BREAK_EN.
// tx/tx_busy are registered from the FSM state, so the line trails the state
// by one cycle; a write into an empty idle block reaches the line 2 edges later.
module uart_tx_fifo_param import uart_pkg::*; #(
  parameter int SYSTEM_CLOCK  = 100000000,
  parameter int UART_BAUDRATE = 115200,
  parameter int DATA_BITS     = 8,
  parameter int PARITY_MODE   = PARITY_NONE,
  parameter int STOP_BITS     = 1,
  parameter int FIFO_DEPTH    = 16
) (
  input  logic system_clk,
  input  logic reset,
`ifdef UART_TX_BREAK_EN
  input  logic tx_break,
`endif
  uart_tx_fifo_param_if.slave bus
);
  localparam int CPB   = clks_per_bit(SYSTEM_CLOCK, UART_BAUDRATE);
  localparam int CB    = clog2(CPB);
  localparam int BIT_W = clog2(DATA_BITS);
  localparam int CNT_W = clog2(FIFO_DEPTH) + 1;

  tx_state_e            state;
  logic [CB-1:0]        baud_cnt;
  logic [BIT_W-1:0]     bit_idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_q, tx_q, busy_q, ovf_q;
  logic                 line_lvl, line_busy;

  logic                 fifo_full, fifo_empty, push, pop;
  logic [DATA_BITS-1:0] fifo_rdata;
  logic [CNT_W-1:0]     fifo_cnt;

  logic pop_ok, idle_lvl, idle_busy;
`ifdef UART_TX_BREAK_EN
  logic brk_rec;  // break released: one high bit time before the next start
  assign pop_ok    = !tx_break && !brk_rec;
  assign idle_lvl  = !tx_break;
  assign idle_busy = tx_break || brk_rec;
`else
  assign pop_ok    = 1'b1;
  assign idle_lvl  = 1'b1;
  assign idle_busy = 1'b0;
`endif

  wire bit_done  = (baud_cnt == CB'(CPB - 1));
  wire stop_last = (state == ST_STOP) && bit_done && (bit_idx == BIT_W'(STOP_BITS - 1));

  // full is the pre-pop status, so a write while full is dropped even on a pop cycle
  assign push = bus.wr_en && !fifo_full;
  assign pop  = !fifo_empty && pop_ok && ((state == ST_IDLE) || stop_last);

  uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (system_clk),
    .rst   (reset),
    .push  (push),
    .pop   (pop),
    .wdata (bus.din),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_cnt)
  );

  always_comb begin
    line_lvl = 1'b1;
    unique case (state)
      ST_IDLE:   line_lvl = idle_lvl;
      ST_START:  line_lvl = 1'b0;
      ST_DATA:   line_lvl = shreg[0];
      ST_PARITY: line_lvl = par_q;
      default:   line_lvl = 1'b1;
    endcase
  end
  assign line_busy = (state != ST_IDLE) || idle_busy;

  always_ff @(posedge system_clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_rec  <= 1'b0;
`endif
    end else begin
      tx_q     <= line_lvl;
      busy_q   <= line_busy;
      ovf_q    <= bus.wr_en && fifo_full;
      baud_cnt <= bit_done ? '0 : baud_cnt + 1'b1;
      if (pop) begin
        shreg <= fifo_rdata;
        par_q <= (^fifo_rdata) ^ (PARITY_MODE == PARITY_ODD);
      end
      unique case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
`ifdef UART_TX_BREAK_EN
          if (tx_break) brk_rec <= 1'b1;
          else if (brk_rec) begin
            baud_cnt <= bit_done ? '0 : baud_cnt + 1'b1;
            if (bit_done) brk_rec <= 1'b0;
          end
`endif
          if (pop) state <= ST_START;
        end
        ST_START:
          if (bit_done) begin
            state   <= ST_DATA;
            bit_idx <= '0;
          end
        ST_DATA:
          if (bit_done) begin
            shreg <= shreg >> 1;
            if (bit_idx == BIT_W'(DATA_BITS - 1)) begin
              bit_idx <= '0;
              state   <= (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
            end else bit_idx <= bit_idx + 1'b1;
          end
        ST_PARITY:
          if (bit_done) begin
            state   <= ST_STOP;
            bit_idx <= '0;
          end
        ST_STOP:
          if (bit_done) begin
            if (stop_last) state <= pop ? ST_START : ST_IDLE;
            else bit_idx <= bit_idx + 1'b1;
          end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.tx         = tx_q;
  assign bus.tx_busy    = busy_q;
  assign bus.overflow   = ovf_q;
  assign bus.full       = fifo_full;
  assign bus.fifo_count = fifo_cnt;
endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// tb_uart_tx_fifo_param: five DUT configurations (8N1, 8E1, 8O1, 8N1 depth 4,
// 7N2) at 16 clocks/bit, driven by directed and random writes and compared every
// cycle against a frame-timeline reference model.
module tb_uart_tx_fifo_param;
  localparam int NI  = 5;
  localparam int CPB = 16;
  localparam int DB [NI] = '{8, 8, 8, 8, 7};
  localparam int PM [NI] = '{0, 2, 1, 0, 0};
  localparam int SB [NI] = '{1, 1, 1, 1, 2};
  localparam int FD [NI] = '{16, 16, 16, 4, 16};

  logic gclk = 1'b0;
  always #5 gclk = ~gclk;

  logic [NI-1:0]      rst, wr, tx_o, busy_o, full_o, ovf_o;
  logic [NI-1:0][8:0] dsel;
  logic [NI-1:0][4:0] cnt_o;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int CW = $clog2(FD[gi]) + 1;
    uart_tx_fifo_param_if #(.DATA_BITS(DB[gi]), .CNT_W(CW)) bus ();
    assign bus.din     = dsel[gi][DB[gi]-1:0];
    assign bus.wr_en   = wr[gi];
    assign tx_o[gi]    = bus.tx;
    assign busy_o[gi]  = bus.tx_busy;
    assign full_o[gi]  = bus.full;
    assign ovf_o[gi]   = bus.overflow;
    assign cnt_o[gi]   = 5'(bus.fifo_count);
    uart_tx_fifo_param #(
      .SYSTEM_CLOCK(1600), .UART_BAUDRATE(100), .DATA_BITS(DB[gi]),
      .PARITY_MODE(PM[gi]), .STOP_BITS(SB[gi]), .FIFO_DEPTH(FD[gi])
    ) dut (
      .system_clk (gclk),
      .reset      (rst[gi]),
`ifdef UART_TX_BREAK_EN
      .tx_break   (1'b0),
`endif
      .bus        (bus.slave)
    );
  end

  // Reference model: a queue of pending words and the timeline of the frame
  // on the line. A frame starting at edge s shows bit k on tx after edges
  // s+1+k*CPB .. and lasts frame_len cycles; the next frame may start on the
  // edge where the previous one completes.
  int unsigned mq [NI][$];
  bit          act [NI];
  int          age [NI];
  logic [15:0] fr [NI];
  bit          n_tx [NI], n_busy [NI];
  bit          e_tx [NI], e_busy [NI], e_ovf [NI];
  int          e_cnt [NI];
  bit          chk_en = 1'b0;

  function automatic int flen(input int i);
    return (1 + DB[i] + ((PM[i] != 0) ? 1 : 0) + SB[i]) * CPB;
  endfunction

  always @(posedge gclk) begin : p_model
    logic [8:0] w;
    bit fullb;
    for (int i = 0; i < NI; i++) begin
      if (rst[i]) begin
        mq[i].delete();
        act[i] = 1'b0; age[i] = 0;
        e_tx[i] = 1'b1; e_busy[i] = 1'b0; e_ovf[i] = 1'b0;
        n_tx[i] = 1'b1; n_busy[i] = 1'b0;
      end else begin
        e_tx[i]   = n_tx[i];
        e_busy[i] = n_busy[i];
        fullb = (mq[i].size() == FD[i]);
        if (act[i]) begin
          age[i]++;
          if (age[i] == flen(i)) act[i] = 1'b0;
        end
        if (!act[i] && mq[i].size() > 0) begin
          w = 9'(mq[i].pop_front());
          fr[i] = '1;
          fr[i][0] = 1'b0;
          for (int k = 0; k < DB[i]; k++) fr[i][1+k] = w[k];
          if (PM[i] != 0) fr[i][1+DB[i]] = (^w) ^ (PM[i] == 1);
          act[i] = 1'b1; age[i] = 0;
        end
        n_tx[i]   = act[i] ? fr[i][age[i]/CPB] : 1'b1;
        n_busy[i] = act[i];
        e_ovf[i]  = wr[i] && fullb;
        if (wr[i] && !fullb) begin
          w = dsel[i] & 9'((1 << DB[i]) - 1);
          mq[i].push_back(32'(w));
        end
      end
      e_cnt[i] = mq[i].size();
    end
  end

  always @(negedge gclk) begin
    if (chk_en)
      for (int i = 0; i < NI; i++) begin
        chk($sformatf("tx[%0d]", i),    32'(tx_o[i]),   32'(e_tx[i]));
        chk($sformatf("busy[%0d]", i),  32'(busy_o[i]), 32'(e_busy[i]));
        chk($sformatf("ovf[%0d]", i),   32'(ovf_o[i]),  32'(e_ovf[i]));
        chk($sformatf("count[%0d]", i), 32'(cnt_o[i]),  32'(e_cnt[i]));
        chk($sformatf("full[%0d]", i),  32'(full_o[i]), 32'(e_cnt[i] == FD[i]));
      end
  end

  // busy run lengths, overflow pulses, peak queue depth of instance 0
  int run [NI], last_run [NI], ovf_n [NI];
  int peak0 = 0;
  always @(negedge gclk) begin
    for (int i = 0; i < NI; i++) begin
      if (busy_o[i] === 1'b1) run[i]++;
      else if (run[i] != 0) begin
        last_run[i] = run[i];
        run[i] = 0;
      end
      if (ovf_o[i] === 1'b1) ovf_n[i]++;
    end
    if (int'(cnt_o[0]) > peak0) peak0 = int'(cnt_o[0]);
  end

  bit exp_bits [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};

  initial begin
    rst = '1; wr = '0; dsel = '0;
    @(posedge gclk);
    chk_en = 1'b1;
    repeat (2) @(posedge gclk);
    @(negedge gclk);
    chk("rst_tx",    32'(tx_o[0]),   32'd1);
    chk("rst_busy",  32'(busy_o[0]), 32'd0);
    chk("rst_count", 32'(cnt_o[0]),  32'd0);
    rst = '0;

    // one frame on every instance; instance 3 then gets 6 writes while busy
    wr = '1;
    dsel[0] = 9'h0A5; dsel[1] = 9'h0A5; dsel[2] = 9'h0A5;
    dsel[3] = 9'h011; dsel[4] = 9'h155;
    @(negedge gclk);                         // after E0
    wr = '0;
    @(negedge gclk);                         // after E0+1
    chk("lat_e1_tx", 32'(tx_o[0]), 32'd1);
    for (int k = 0; k < 6; k++) begin
      wr[3] = 1'b1; dsel[3] = 9'(k + 2);
      @(negedge gclk);
      if (k == 0) begin                      // after E0+2
        chk("lat_e2_tx",   32'(tx_o[0]),   32'd0);
        chk("lat_e2_busy", 32'(busy_o[0]), 32'd1);
      end
    end
    wr[3] = 1'b0;                            // after E0+7
    repeat (3) @(negedge gclk);              // after E0+10: mid start bit
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("midbit%0d", k), 32'(tx_o[0]), 32'(exp_bits[k]));
      if (k == 9) begin
        chk("parity_even", 32'(tx_o[1]), 32'd0);
        chk("parity_odd",  32'(tx_o[2]), 32'd1);
      end
      repeat (16) @(negedge gclk);
    end
    repeat (730) @(negedge gclk);            // after E0+900
    chk("run_8n1",    32'(last_run[0]), 32'd160);
    chk("run_8e1",    32'(last_run[1]), 32'd176);
    chk("run_8o1",    32'(last_run[2]), 32'd176);
    chk("run_d4_5fr", 32'(last_run[3]), 32'd800);
    chk("ovf_pulses", 32'(ovf_n[3]),    32'd2);
    chk("run_7n2",    32'(last_run[4]), 32'd160);

    // three words on consecutive cycles go out back-to-back
    peak0 = 0;
    wr[0] = 1'b1; dsel[0] = 9'h05A;
    @(negedge gclk); dsel[0] = 9'h0AA;
    @(negedge gclk); dsel[0] = 9'h03C;
    @(negedge gclk); wr[0] = 1'b0;
    repeat (520) @(negedge gclk);
    chk("run_b2b",  32'(last_run[0]), 32'd480);
    chk("peak_cnt", 32'(peak0),       32'd2);

    // random traffic, including upper din bits and overflow bursts
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NI; i++) begin
        wr[i]   = ($urandom_range(0, (i == 3) ? 9 : 29) == 0);
        dsel[i] = 9'($urandom_range(0, 511));
      end
      @(negedge gclk);
    end
    wr = '0;

    // reset in the middle of a frame with more words queued
    rst[0] = 1'b1;
    @(negedge gclk);
    rst[0] = 1'b0; wr[0] = 1'b1; dsel[0] = 9'h0C3;
    @(negedge gclk); dsel[0] = 9'h011;
    @(negedge gclk); wr[0] = 1'b0;
    begin
      int n;
      n = 0;
      while (busy_o[0] !== 1'b1 && n < 50) begin
        @(negedge gclk);
        n++;
      end
      chk("busy_rise_in_time", 32'(n < 50), 32'd1);
    end
    repeat (48) @(negedge gclk);
    rst[0] = 1'b1;
    @(negedge gclk);
    rst[0] = 1'b0;
    chk("midrst_tx",    32'(tx_o[0]),   32'd1);
    chk("midrst_busy",  32'(busy_o[0]), 32'd0);
    chk("midrst_count", 32'(cnt_o[0]),  32'd0);
    begin
      int post;
      post = 0;
      repeat (400) begin
        @(negedge gclk);
        if (busy_o[0] !== 1'b0) post++;
      end
      chk("no_frames_after_rst", 32'(post), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
